rr_priority_arbiter: RTL and testbench

//  Parametrised, registered N-input arbiter; sequential successor to the 8x3 priority encoders.

---
 rtl/rr_priority_arbiter_if.sv | 28 ++
 rtl/rr_priority_arbiter.sv | 100 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rr_priority_arbiter_if.sv
// rtl/rr_priority_arbiter_if.sv - request/grant bundle for rr_priority_arbiter
//
// Purpose: groups the request side (req, mode, lock) and the registered
// grant side (gnt, gnt_idx, valid) of the arbiter.
// Ports (signals):
//   req      N  request vector, bit i = requester i
//   mode     1  0 = fixed priority (highest index wins), 1 = round-robin
//   lock     1  1 = keep current grant while its req bit stays high
//   gnt      N  one-hot grant, zero when nothing is granted
//   gnt_idx  W  binary index of the granted requester, 0 when no grant
//   valid    1  1 when gnt is non-zero
// Modports: master drives requests, slave (the arbiter) drives grants.
interface rr_priority_arbiter_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         mode;
  logic         lock;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         valid;

  modport master (output req, output mode, output lock,
                  input gnt, input gnt_idx, input valid);
  modport slave  (input req, input mode, input lock,
                  output gnt, output gnt_idx, output valid);
endinterface

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - registered N-input fixed-priority / round-robin arbiter
//
// Purpose: registered arbiter with selectable fixed-priority or round-robin
// mode and an optional grant lock.
// Ports:
//   clk  in  single clock, all state updates on posedge
//   rst  in  synchronous, active-high reset
//   bus  slave modport of rr_priority_arbiter_if (req/mode/lock in,
//        gnt/gnt_idx/valid out, all outputs registered)
module rr_priority_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_priority_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] gnt_q, gnt_nxt;
  logic [W-1:0] idx_q, idx_nxt;
  logic [W-1:0] ptr_q, ptr_nxt;

  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W:0]   rr_sum;
  logic [W-1:0] rr_pos;
  logic [W-1:0] new_idx;
  logic         hold;

  // Highest set index: later iterations overwrite earlier ones.
  always_comb begin
    fixed_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[W'(i)]) fixed_idx = W'(i);
    end
  end

  // Scan ptr, ptr+1, ... wrapping to 0 at N (not at 2**W), first hit wins.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_pos   = '0;
    for (int off = 0; off < N; off++) begin
      rr_sum = {1'b0, ptr_q} + (W+1)'(off);
      if (rr_sum >= (W+1)'(N)) rr_sum = rr_sum - (W+1)'(N);
      rr_pos = rr_sum[W-1:0];
      if (!rr_found && bus.req[rr_pos]) begin
        rr_idx   = rr_pos;
        rr_found = 1'b1;
      end
    end
  end

  assign hold    = (state == GRANT) && bus.lock && bus.req[idx_q];
  assign new_idx = bus.mode ? rr_idx : fixed_idx;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr_q;
    if (hold) begin
      state_nxt = GRANT;
    end else if (bus.req == '0) begin
      // Going idle leaves the round-robin pointer where it was.
      state_nxt = IDLE;
      gnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      state_nxt = GRANT;
      idx_nxt   = new_idx;
      gnt_nxt   = N'(1) << new_idx;
      ptr_nxt   = (new_idx == W'(N-1)) ? '0 : new_idx + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      idx_q <= idx_nxt;
      ptr_q <= ptr_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.valid   = (state == GRANT);

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - self-checking bench for rr_priority_arbiter
module tb_rr_priority_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Reference state kept as plain integers.
  int m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter_if #(.N(N)) bus ();

  rr_priority_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic [7:0] q, input logic md, input logic lk);
    int hit;
    if (r) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (m_valid == 1 && lk && q[m_idx]) begin
      // locked grant held
    end else if (q == 8'h00) begin
      m_valid = 0; m_idx = 0;
    end else begin
      hit = -1;
      if (!md) begin
        for (int i = N - 1; i >= 0; i--) if (hit < 0 && q[i]) hit = i;
      end else begin
        for (int k = 0; k < N; k++) if (hit < 0 && q[(m_ptr + k) % N]) hit = (m_ptr + k) % N;
      end
      m_valid = 1;
      m_idx   = hit;
      m_ptr   = (hit + 1) % N;
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic md, input logic lk);
    rst      = r;
    bus.req  = q;
    bus.mode = md;
    bus.lock = lk;
    @(posedge clk);
    model_update(r, q, md, lk);
    #1;
    chk("gnt",     32'(bus.gnt),     (m_valid == 1) ? (32'd1 << m_idx) : 32'd0);
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
    chk("valid",   32'(bus.valid),   32'(m_valid));
  endtask

  task automatic exp_idx(input string tag, input int e);
    chk(tag, 32'(bus.gnt_idx), 32'(e));
  endtask

  initial begin
    rst = 1'b1; bus.req = '0; bus.mode = 1'b0; bus.lock = 1'b0;

    // 1. reset with all requests, then fixed priority
    step(1, 8'hFF, 0, 0);
    step(1, 8'hFF, 0, 0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_gnt",   32'(bus.gnt),   32'd0);
    step(0, 8'hFF, 0, 0);
    chk("fixed_gnt", 32'(bus.gnt), 32'h80);
    exp_idx("fixed_idx", 7);

    // 2. round-robin over 1010_0101
    step(1, 8'h00, 0, 0);
    step(0, 8'hA5, 1, 0); exp_idx("rr0", 0);
    step(0, 8'hA5, 1, 0); exp_idx("rr1", 2);
    step(0, 8'hA5, 1, 0); exp_idx("rr2", 5);
    step(0, 8'hA5, 1, 0); exp_idx("rr3", 7);
    step(0, 8'hA5, 1, 0); exp_idx("rr4", 0);

    // 3. pointer wrap
    step(1, 8'h00, 0, 0);
    step(0, 8'h81, 1, 0); exp_idx("wrap0", 0);
    step(0, 8'h81, 1, 0); exp_idx("wrap1", 7);
    step(0, 8'h81, 1, 0); chk("wrap2_gnt", 32'(bus.gnt), 32'h01);
    step(0, 8'h81, 1, 0); exp_idx("wrap3", 7);

    // 4. lock hold and release
    step(1, 8'h00, 0, 0);
    step(0, 8'h06, 1, 1); exp_idx("lock0", 1);
    step(0, 8'h06, 1, 1); exp_idx("lock1", 1);
    step(0, 8'h06, 1, 1); exp_idx("lock2", 1);
    step(0, 8'h04, 1, 1); exp_idx("lock_rel", 2);
    step(0, 8'h00, 1, 1); chk("lock_idle", 32'(bus.valid), 32'd0);

    // 5. idle keeps pointer
    step(1, 8'h00, 0, 0);
    step(0, 8'h08, 1, 0); exp_idx("idle_g", 3);
    step(0, 8'h00, 1, 0); chk("idle_v0", 32'(bus.valid), 32'd0);
    step(0, 8'h00, 1, 0); exp_idx("idle_i0", 0);
    step(0, 8'hFF, 1, 0); exp_idx("idle_next", 4);

    // 6. reset mid-lock
    step(1, 8'h00, 0, 0);
    step(0, 8'h20, 1, 1); exp_idx("ml_g", 5);
    step(1, 8'h20, 1, 1); chk("ml_valid", 32'(bus.valid), 32'd0);
    step(0, 8'hFF, 1, 0); exp_idx("ml_after", 0);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic [7:0] q;
      r = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 3))
        0:       q = 8'h00;
        1:       q = 8'(1 << $urandom_range(0, 7));
        default: q = 8'($urandom);
      endcase
      step(r, q, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
